wb_commit_sched: RTL

Scheduler between the dual-issue writeback stage (lanes alpha/beta) and the single-entry-per-cycle debug commit trace port. Buffers qualifying register writes in program order (alpha before beta) and releases one per cycle under a valid/ready handshake. Applies backpressure to the W stage through a registered stall request, so the buffer never overflows.

---
 rtl/wb_commit_sched_pkg.sv | 19 +
 rtl/wb_commit_sched_queue.sv | 46 ++++
 rtl/wb_commit_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/wb_commit_sched_pkg.sv
// Shared types for the writeback-to-commit-trace scheduler.
package wb_commit_sched_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } commit_entry_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } sched_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_commit_sched_queue.sv
// Circular entry buffer with two write ports (in-order slots wr, wr+1) and one read port.
module commit_queue_2w1r
  import wb_commit_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    n_push,
  input  commit_entry_t wr0_data,
  input  commit_entry_t wr1_data,
  input  logic          pop,
  output commit_entry_t head,
  output logic [AW:0]   occupancy,
  output logic [AW:0]   occ_next
);

  commit_entry_t mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, wr_idx1;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign wr_idx1 = wr_idx + AW'(1);

  // Storage is never reset; stale entries stay hidden behind the pointers.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wr_idx]  <= wr0_data;
    if (n_push == 2'd2) mem[wr_idx1] <= wr1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(n_push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
    end
  end

  assign occupancy = wr_ptr - rd_ptr;
  assign occ_next  = occupancy + (AW+1)'(n_push) - (AW+1)'(pop);
  assign head      = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/wb_commit_sched.sv
// Orders dual-lane register writes into a single commit trace stream with registered W-stage backpressure.
module wb_commit_sched
  import wb_commit_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_stall,
  input  logic [31:0] alpha_pc,
  input  logic [3:0]  alpha_wen,
  input  logic [4:0]  alpha_wnum,
  input  logic [31:0] alpha_wdata,
  input  logic [31:0] beta_pc,
  input  logic [3:0]  beta_wen,
  input  logic [4:0]  beta_wnum,
  input  logic [31:0] beta_wdata,
  output logic        sched_stall_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_wen,
  output logic [4:0]  out_wnum,
  output logic [31:0] out_wdata,
  output logic [AW:0] occupancy,
  output logic [31:0] commit_cnt
);

  sched_state_e  state, state_next;
  commit_entry_t alpha_e, beta_e, wr0_data, wr1_data, head;
  logic          alpha_q, beta_q, pop;
  logic [1:0]    n_push;
  logic [AW:0]   occ_next;

  assign alpha_e = '{pc: alpha_pc, wen: alpha_wen, wnum: alpha_wnum, wdata: alpha_wdata};
  assign beta_e  = '{pc: beta_pc,  wen: beta_wen,  wnum: beta_wnum,  wdata: beta_wdata};

  assign sched_stall_req = (state == STALL);
  assign alpha_q = (alpha_wen != '0) && (alpha_wnum != REG_ZERO) && !w_stall && !sched_stall_req;
  assign beta_q  = (beta_wen  != '0) && (beta_wnum  != REG_ZERO) && !w_stall && !sched_stall_req;
  assign n_push  = {1'b0, alpha_q} + {1'b0, beta_q};

  // Compact qualifying lanes onto write port 0 first so program order is kept.
  assign wr0_data = alpha_q ? alpha_e : beta_e;
  assign wr1_data = beta_e;

  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;

  commit_queue_2w1r #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .n_push    (n_push),
    .wr0_data  (wr0_data),
    .wr1_data  (wr1_data),
    .pop       (pop),
    .head      (head),
    .occupancy (occupancy),
    .occ_next  (occ_next)
  );

  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_wen   = out_valid ? head.wen   : '0;
  assign out_wnum  = out_valid ? head.wnum  : '0;
  assign out_wdata = out_valid ? head.wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      commit_cnt <= '0;
    end else begin
      state      <= state_next;
      commit_cnt <= commit_cnt + 32'(pop);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY, ACTIVE: begin
        if (occ_next == '0)                         state_next = EMPTY;
        else if (occ_next >= (AW+1)'(DEPTH - 1))    state_next = STALL;
        else                                        state_next = ACTIVE;
      end
      STALL: begin
        if (occ_next == '0)                         state_next = EMPTY;
        else if (occ_next <= (AW+1)'(DEPTH - 2))    state_next = ACTIVE;
        else                                        state_next = STALL;
      end
      default:                                      state_next = EMPTY;
    endcase
  end

endmodule
